// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART subsystem constants and helpers
package uart_pkg;

    localparam logic IDLE = 1'b0;
    localparam logic SEND = 1'b1;

    localparam int UART_DW = 8;
    localparam int CNT_W   = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first set bit after ptr
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            any
);

    int idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    always_comb begin
        win = '0;
        idx = 0;
        any = |req;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin share of one UART transmitter
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = UART_DW,
    parameter int MAX_LEN = 64,
    parameter int IDLE_TO = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               tx_valid,
    output logic [DW-1:0]      tx_data,
    input  logic               tx_ready,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic               msg_done,
    output logic               msg_trunc,
    output logic               msg_abort
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] LEN_LIM  = CNT_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_TO - 1);

    logic             state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    g_idx;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic [NREQ-1:0]  pick;
    logic             pick_any;
    logic             g_last;
    logic             xfer;

    rr_pick #(
        .NREQ(NREQ),
        .PW  (PW)
    ) u_pick (
        .req(req_valid),
        .ptr(ptr),
        .win(pick),
        .any(pick_any)
    );

    // Only the granted lane is muxed through; everything else sees ready low.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        g_last    = 1'b0;
        g_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                tx_valid     = req_valid[i];
                tx_data      = req_data[i*DW +: DW];
                req_ready[i] = tx_ready;
                g_last       = req_last[i];
                g_idx        = PW'(i);
            end
        end
    end

    assign busy = |grant;
    assign xfer = tx_valid && tx_ready;

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= PW'(NREQ - 1);
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            msg_done  <= 1'b0;
            msg_trunc <= 1'b0;
            msg_abort <= 1'b0;
        end else begin
            msg_done  <= 1'b0;
            msg_trunc <= 1'b0;
            msg_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (xfer && (g_last || byte_cnt >= LEN_LIM)) begin
                        msg_done  <= g_last;
                        msg_trunc <= !g_last;
                        state     <= IDLE;
                        grant     <= '0;
                        ptr       <= g_idx;
                        byte_cnt  <= '0;
                        idle_cnt  <= '0;
                    end else if (!tx_valid && idle_cnt >= IDLE_LIM) begin
                        msg_abort <= 1'b1;
                        state     <= IDLE;
                        grant     <= '0;
                        ptr       <= g_idx;
                        byte_cnt  <= '0;
                        idle_cnt  <= '0;
                    end else if (xfer) begin
                        byte_cnt <= sat_inc(byte_cnt);
                        idle_cnt <= '0;
                    end else if (!tx_valid) begin
                        idle_cnt <= sat_inc(idle_cnt);
                    end
                    // valid high with tx_ready low: UART stall, idle_cnt holds
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk1 = 1'b0;
    logic              rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               tx_valid;
    logic [DW-1:0]      tx_data;
    logic               tx_ready;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               msg_done;
    logic               msg_trunc;
    logic               msg_abort;

    uart_tx_arbiter #(
        .NREQ(NREQ), .DW(DW), .MAX_LEN(64), .IDLE_TO(16)
    ) dut (
        .clk1(clk1), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant(grant), .busy(busy),
        .msg_done(msg_done), .msg_trunc(msg_trunc), .msg_abort(msg_abort)
    );

    always #5 clk1 = ~clk1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0]      mem [NREQ][128];
    logic            lst [NREQ][128];
    int              rd  [NREQ];
    int              wr  [NREQ];
    logic [NREQ-1:0] en;

    int lg_req[$];
    int lg_dat[$];
    int lg_cyc[$];
    int cnt_done  = 0;
    int cnt_trunc = 0;
    int cnt_abort = 0;
    int cyc_trunc = 0;

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = en[i] && (rd[i] < wr[i]);
            req_data[i*DW +: DW]  = (rd[i] < wr[i]) ? mem[i][rd[i]] : 8'h00;
            req_last[i]           = (rd[i] < wr[i]) ? lst[i][rd[i]] : 1'b0;
        end
    endtask

    task automatic push_msg(input int r, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            mem[r][wr[r]] = 8'(base + k);
            lst[r][wr[r]] = (k == n - 1);
            wr[r]++;
        end
        drive();
    endtask

    // Sample at negedge, advance requester queues just after the rising edge.
    task automatic tick();
        logic [NREQ-1:0] hs;
        @(negedge clk1);
        cyc++;
        hs = req_valid & req_ready;
        if (tx_valid && tx_ready) begin
            lg_req.push_back(oh_idx(grant));
            lg_dat.push_back(int'(tx_data));
            lg_cyc.push_back(cyc);
        end
        if (msg_done) cnt_done++;
        if (msg_trunc) begin
            cnt_trunc++;
            cyc_trunc = cyc;
        end
        if (msg_abort) cnt_abort++;
        n_cmp++;
        if ((req_ready & ~grant) !== '0) begin
            n_bad++;
            $display("FAIL ready_ungranted: req_ready=%b grant=%b required no ready outside grant", req_ready, grant);
        end
        @(posedge clk1);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (hs[i]) rd[i]++;
        drive();
    endtask

    task automatic check_log(input string name, input int at, input int r, input int d);
        n_cmp++;
        if (lg_req.size() <= at) begin
            n_bad++;
            $display("FAIL %s: log has %0d entries, required entry %0d", name, lg_req.size(), at);
        end else if (lg_req[at] != r || lg_dat[at] != d) begin
            n_bad++;
            $display("FAIL %s: got req %0d data %h, required req %0d data %h", name, lg_req[at], lg_dat[at], r, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tx_ready = 1'b1;
        en = '1;
        for (int i = 0; i < NREQ; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk1);
        #1;
        n_cmp++;
        if ({grant, busy, tx_valid, tx_data, req_ready, msg_done, msg_trunc, msg_abort} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: grant=%b busy=%b tx_valid=%b tx_data=%h req_ready=%b pulses=%b%b%b, required all 0",
                     grant, busy, tx_valid, tx_data, req_ready, msg_done, msg_trunc, msg_abort);
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        int b = lg_req.size();
        push_msg(1, 3, 8'h41);
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_pre: grant=%b required 0000", grant);
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0010 || tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            n_bad++;
            $display("FAIL single_grant: grant=%b tx_valid=%b tx_data=%h required 0010 1 41", grant, tx_valid, tx_data);
        end
        repeat (3) tick();
        n_cmp++;
        if (grant !== 4'b0000 || busy !== 1'b0 || msg_done !== 1'b1 || msg_trunc !== 1'b0) begin
            n_bad++;
            $display("FAIL single_release: grant=%b busy=%b done=%b trunc=%b required 0000 0 1 0", grant, busy, msg_done, msg_trunc);
        end
        tick();
        n_cmp++;
        if (msg_done !== 1'b0 || grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_pulse_width: done=%b grant=%b required 0 0000", msg_done, grant);
        end
        for (int k = 0; k < 3; k++) check_log("single_data", b + k, 1, 8'h41 + k);
        n_cmp++;
        if (lg_cyc.size() < b + 3 || lg_cyc[b+2] - lg_cyc[b] != 2) begin
            n_bad++;
            $display("FAIL single_consecutive: %0d transfers logged, required 3 in consecutive cycles", lg_cyc.size() - b);
        end
    endtask

    task automatic test_round_robin();
        int b;
        int d0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        b = lg_req.size();
        d0 = cnt_done;
        push_msg(0, 2, 8'h10);
        push_msg(2, 2, 8'h20);
        repeat (10) tick();
        check_log("rr_first_a", b + 0, 0, 8'h10);
        check_log("rr_first_b", b + 1, 0, 8'h11);
        check_log("rr_second_a", b + 2, 2, 8'h20);
        check_log("rr_second_b", b + 3, 2, 8'h21);
        n_cmp++;
        if (lg_cyc.size() < b + 3 || lg_cyc[b+2] - lg_cyc[b+1] != 2) begin
            n_bad++;
            $display("FAIL rr_gap: cycles between grants wrong, required exactly one idle cycle");
        end
        push_msg(0, 2, 8'h30);
        push_msg(3, 2, 8'h40);
        repeat (10) tick();
        check_log("rr_wrap_a", b + 4, 3, 8'h40);
        check_log("rr_wrap_b", b + 5, 3, 8'h41);
        check_log("rr_wrap_c", b + 6, 0, 8'h30);
        check_log("rr_wrap_d", b + 7, 0, 8'h31);
        n_cmp++;
        if (cnt_done - d0 != 4) begin
            n_bad++;
            $display("FAIL rr_done_count: got %0d msg_done pulses, required 4", cnt_done - d0);
        end
    endtask

    task automatic test_stall();
        int b = lg_req.size();
        int a0 = cnt_abort;
        push_msg(0, 3, 8'h54);
        tick();
        tick();
        tx_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++;
            if ({grant, tx_valid, tx_data, msg_abort} !== {4'b0001, 1'b1, 8'h55, 1'b0}) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: grant=%b tx_valid=%b tx_data=%h abort=%b required 0001 1 55 0",
                         k, grant, tx_valid, tx_data, msg_abort);
            end
        end
        tx_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (msg_done !== 1'b1 || grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL stall_done: done=%b grant=%b required 1 0000", msg_done, grant);
        end
        check_log("stall_a", b + 0, 0, 8'h54);
        check_log("stall_b", b + 1, 0, 8'h55);
        check_log("stall_c", b + 2, 0, 8'h56);
        n_cmp++;
        if (cnt_abort != a0) begin
            n_bad++;
            $display("FAIL stall_abort: got %0d abort pulses, required 0", cnt_abort - a0);
        end
    endtask

    task automatic test_abort();
        int b = lg_req.size();
        int a0 = cnt_abort;
        push_msg(3, 2, 8'h60);
        tick();
        tick();
        en[3] = 1'b0;
        push_msg(1, 1, 8'h70);
        repeat (15) tick();
        n_cmp++;
        if (grant !== 4'b1000 || msg_abort !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_early: grant=%b abort=%b after 15 idle cycles, required 1000 0", grant, msg_abort);
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || msg_abort !== 1'b1 || busy !== 1'b0 || msg_done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_fire: grant=%b abort=%b busy=%b done=%b after 16 idle cycles, required 0000 1 0 0",
                     grant, msg_abort, busy, msg_done);
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0010 || msg_abort !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_regrant: grant=%b abort=%b required 0010 0", grant, msg_abort);
        end
        tick();
        en[3] = 1'b1;
        drive();
        repeat (4) tick();
        check_log("abort_a", b + 0, 3, 8'h60);
        check_log("abort_b", b + 1, 1, 8'h70);
        check_log("abort_c", b + 2, 3, 8'h61);
        n_cmp++;
        if (cnt_abort - a0 != 1) begin
            n_bad++;
            $display("FAIL abort_count: got %0d abort pulses, required 1", cnt_abort - a0);
        end
    endtask

    task automatic test_trunc();
        int b = lg_req.size();
        int t0 = cnt_trunc;
        int d0 = cnt_done;
        push_msg(2, 70, 8'h80);
        repeat (80) tick();
        for (int k = 0; k < 70; k++) check_log("trunc_data", b + k, 2, 8'h80 + k);
        n_cmp++;
        if (cnt_trunc - t0 != 1 || cnt_done - d0 != 1) begin
            n_bad++;
            $display("FAIL trunc_pulses: trunc=%0d done=%0d, required 1 1", cnt_trunc - t0, cnt_done - d0);
        end
        n_cmp++;
        if (lg_cyc.size() < b + 65 || cyc_trunc != lg_cyc[b+63] + 1 || lg_cyc[b+64] - lg_cyc[b+63] != 2) begin
            n_bad++;
            $display("FAIL trunc_timing: trunc at cycle %0d, required one cycle after byte 64 and regrant after one idle cycle",
                     cyc_trunc);
        end
    endtask

    task automatic test_reset_mid();
        int b = lg_req.size();
        int d0 = cnt_done;
        int t0 = cnt_trunc;
        int a0 = cnt_abort;
        push_msg(1, 5, 8'h90);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({grant, req_ready, tx_valid, busy, tx_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: grant=%b req_ready=%b tx_valid=%b busy=%b tx_data=%h required all 0",
                     grant, req_ready, tx_valid, busy, tx_data);
        end
        rd[1] = wr[1];
        drive();
        tick();
        tick();
        rst = 1'b1;
        push_msg(3, 1, 8'hA0);
        push_msg(0, 1, 8'hB0);
        repeat (6) tick();
        check_log("rstmid_a", b + 0, 1, 8'h90);
        check_log("rstmid_b", b + 1, 1, 8'h91);
        check_log("rstmid_prio", b + 2, 0, 8'hB0);
        check_log("rstmid_next", b + 3, 3, 8'hA0);
        n_cmp++;
        if (cnt_done - d0 != 2 || cnt_trunc != t0 || cnt_abort != a0) begin
            n_bad++;
            $display("FAIL rstmid_pulses: done=%0d trunc=%0d abort=%0d, required 2 0 0",
                     cnt_done - d0, cnt_trunc - t0, cnt_abort - a0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_abort();
        test_trunc();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
